rst_seq: RTL and testbench

//  Reset sequencer for the KS10 FPGA clock domain.
//  - Synchronizes the asynchronous PLL/DCM lock input.
//  - Filters the lock input for stability.
//  - Releases STAGES reset domains one at a time (bus, CPU, devices, console) with DELAY cycles between releases.
//  - On lock loss or a software reset request, re-asserts every domain at once.

---
 rtl/ks10_rst_pkg.sv | 22 ++
 rtl/rst_sync2.sv | 21 ++
 rtl/rst_seq.sv | 137 +++++++++++++
 tb/tb_rst_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ks10_rst_pkg.sv
// Shared constants and FSM state encoding for the KS10 reset sequencer.
package ks10_rst_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      RELEASE   = 2'd1,
      RUN       = 2'd2,
      HOLD      = 2'd3
   } rst_state_t;

   localparam int DEF_STAGES    = 4;
   localparam int DEF_DELAY     = 16;
   localparam int DEF_LOCK_FILT = 8;
   localparam int DEF_WDOG      = 65536;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rst_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by rst.
module rst_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rst_seq.sv
// KS10 reset sequencer: filters PLL lock, then releases reset domains in order.
// Optional lock watchdog is built when RST_SEQ_WDOG_EN is defined.
module rst_seq
   import ks10_rst_pkg::*;
#(
   parameter int STAGES      = DEF_STAGES,
   parameter int DELAY       = DEF_DELAY,
   parameter int LOCK_FILT   = DEF_LOCK_FILT,
   parameter int WDOG_CYCLES = DEF_WDOG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lock,
   input  logic              swrst,
   output logic [STAGES-1:0] rst_o,
   output logic              ready,
   output logic              wdog_err
);

   localparam int CW = $clog2(max3(DELAY, LOCK_FILT, WDOG_CYCLES)) + 1;
   localparam int KW = $clog2(STAGES + 1);

   rst_state_t        state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [KW-1:0]     k, k_n;
   logic [STAGES-1:0] rst_o_n;
   logic              ready_n;
   logic              lock_s;

   rst_sync2 u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (lock),
      .q   (lock_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= WAIT_LOCK;
         cnt   <= '0;
         k     <= '0;
         rst_o <= '1;
         ready <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         k     <= k_n;
         rst_o <= rst_o_n;
         ready <= ready_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      k_n     = k;
      rst_o_n = rst_o;
      ready_n = ready;

      // Lock loss outside WAIT_LOCK overrides everything, including swrst.
      if (state != WAIT_LOCK && !lock_s) begin
         state_n = WAIT_LOCK;
         cnt_n   = '0;
         k_n     = '0;
         rst_o_n = '1;
         ready_n = 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt_n = '0;
               end else if (cnt == CW'(LOCK_FILT - 1)) begin
                  state_n = RELEASE;
                  cnt_n   = '0;
                  k_n     = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (cnt == CW'(DELAY - 1)) begin
                  cnt_n   = '0;
                  rst_o_n = rst_o & ~(STAGES'(1) << k);
                  k_n     = k + 1'b1;
                  if (k == KW'(STAGES - 1)) begin
                     state_n = RUN;
                     ready_n = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            RUN: begin
               if (swrst) begin
                  state_n = HOLD;
                  cnt_n   = '0;
                  rst_o_n = '1;
                  ready_n = 1'b0;
               end
            end
            HOLD: begin
               if (cnt == CW'(DELAY - 1)) begin
                  state_n = WAIT_LOCK;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end
         endcase
      end
   end

`ifdef RST_SEQ_WDOG_EN
   logic [CW-1:0] wcnt;

   // Counter parks at its terminal value so it can never wrap back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt     <= '0;
         wdog_err <= 1'b0;
      end else if (state != WAIT_LOCK) begin
         wcnt <= '0;
      end else if (wcnt == CW'(WDOG_CYCLES - 1)) begin
         wdog_err <= 1'b1;
      end else begin
         wcnt <= wcnt + 1'b1;
      end
   end
`else
   assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues expected output transitions,
// a monitor compares every observed change of {rst_o, ready} against them.
module tb_rst_seq;

`ifdef RST_SEQ_WDOG_EN
   localparam int WDOG = 100;
`else
   localparam int WDOG = 65536;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lock = 1'b0;
   logic       swrst = 1'b0;
   logic [3:0] rst_o;
   logic       ready;
   logic       wdog_err;

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      int unsigned at;
      logic [3:0]  r;
      logic        rd;
   } exp_t;

   exp_t exp_q[$];

   rst_seq #(
      .STAGES      (4),
      .DELAY       (16),
      .LOCK_FILT   (8),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .lock     (lock),
      .swrst    (swrst),
      .rst_o    (rst_o),
      .ready    (ready),
      .wdog_err (wdog_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: any change of outputs outside reset must match the queue head.
   logic [3:0] prev_r;
   logic       prev_rd;
   initial begin
      prev_r  = 4'hF;
      prev_rd = 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_r  = rst_o;
         prev_rd = ready;
      end else if (rst_o !== prev_r || ready !== prev_rd) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change cyc=%0d got rst_o=%h ready=%b, required no change (rst_o=%h ready=%b)",
                     cyc, rst_o, ready, prev_r, prev_rd);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.at || rst_o !== e.r || ready !== e.rd) begin
               fails++;
               $display("FAIL transition got cyc=%0d rst_o=%h ready=%b, required cyc=%0d rst_o=%h ready=%b",
                        cyc, rst_o, ready, e.at, e.r, e.rd);
            end
         end
         prev_r  = rst_o;
         prev_rd = ready;
      end
   end

   task automatic push(input int unsigned at, input logic [3:0] r, input logic rd);
      exp_t e;
      e.at = at; e.r = r; e.rd = rd;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name, input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         step(1);
         n++;
      end
      step(2);
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout pending=%0d, required 0 after %0d cycles", name, exp_q.size(), bound);
         exp_q.delete();
      end
   endtask

   task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got %h required %h", name, got, want);
      end
   endtask

   int unsigned t, r0;

   initial begin
      // Reset state
      step(3);
      check("reset_rst_o", {2'b0, rst_o}, 6'h0F);
      check("reset_ready", {5'b0, ready}, 6'h00);
      check("reset_wdog",  {5'b0, wdog_err}, 6'h00);

      // Release rst with lock low: nothing may change
      @(negedge clk);
      rst = 1'b0;
      r0 = cyc;
`ifdef RST_SEQ_WDOG_EN
      while (cyc < r0 + 99) @(negedge clk);
      check("wdog_before", {5'b0, wdog_err}, 6'h00);
      @(negedge clk);
      check("wdog_at_limit", {5'b0, wdog_err}, 6'h01);
`endif
      step(110);
      check("idle_rst_o", {2'b0, rst_o}, 6'h0F);

      // Clean lock rise: releases at +26,+42,+58,+74
      lock = 1'b1;
      t = cyc;
      push(t + 26, 4'hE, 1'b0);
      push(t + 42, 4'hC, 1'b0);
      push(t + 58, 4'h8, 1'b0);
      push(t + 74, 4'h0, 1'b1);
      drain("first_release", 120);

      // swrst in RUN: hold 16 cycles, refilter 8, release 4x16
      swrst = 1'b1;
      t = cyc;
      step(1);
      swrst = 1'b0;
      push(t + 1,  4'hF, 1'b0);
      push(t + 41, 4'hE, 1'b0);
      push(t + 57, 4'hC, 1'b0);
      push(t + 73, 4'h8, 1'b0);
      push(t + 89, 4'h0, 1'b1);
      drain("swrst", 150);

      // Lock loss in RUN with swrst on the cycle lock_s drops
      lock = 1'b0;
      t = cyc;
      push(t + 3, 4'hF, 1'b0);
      step(2);
      swrst = 1'b1;
      step(1);
      swrst = 1'b0;
      drain("lock_loss_run", 20);
      step(5);

      // Lock loss mid-RELEASE with rst_o=C
      lock = 1'b1;
      t = cyc;
      push(t + 26, 4'hE, 1'b0);
      push(t + 42, 4'hC, 1'b0);
      push(t + 48, 4'hF, 1'b0);
      step(45);
      lock = 1'b0;
      drain("lock_loss_release", 80);

      // swrst outside RUN is ignored
      swrst = 1'b1;
      step(1);
      swrst = 1'b0;
      step(5);

      // 5-cycle lock glitch then final rise: latency counts from the last edge
      lock = 1'b1;
      step(5);
      lock = 1'b0;
      step(3);
      lock = 1'b1;
      t = cyc;
      push(t + 26, 4'hE, 1'b0);
      push(t + 42, 4'hC, 1'b0);
      push(t + 58, 4'h8, 1'b0);
      push(t + 74, 4'h0, 1'b1);
      drain("glitch", 120);

`ifdef RST_SEQ_WDOG_EN
      check("wdog_sticky", {5'b0, wdog_err}, 6'h01);
`else
      check("wdog_tied", {5'b0, wdog_err}, 6'h00);
`endif

      // Asynchronous reset assertion mid-cycle
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_o", {2'b0, rst_o}, 6'h0F);
      check("async_ready", {5'b0, ready}, 6'h00);
      check("async_wdog",  {5'b0, wdog_err}, 6'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
